multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the existing MIPS datapath (register file, ALU, ALU control, sign extension, muxes, data memory) as a multi-cycle processor sharing one memory port between instruction fetch and data access.
- Decodes opcode in instruction[31:26]; drives per-cycle datapath enables and mux selects; waits on memory ready handshake; counts retired instructions; flags memory timeouts.

---
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over one shared memory port.
// Optional build macro MC_ILLEGAL_TRAP_EN routes unknown opcodes to a TRAP state instead of a NOP.
module multicycle_control #(
  parameter int RETIRE_W = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic                mem_timeout,
  output logic                illegal_op
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC+4 on completion
  // DECODE | dispatch on opcode, precompute branch target
  // MEMADR | compute lw/sw effective address
  // MEMRD  | data read in flight
  // MEMWB  | write loaded data to rt
  // MEMWR  | data write in flight
  // EXEC   | R-type ALU operation
  // ALUWB  | write ALU result to rd
  // BRANCH | beq compare, conditional PC load
  // JUMP   | load jump target
  // ADDIEX | rs + imm
  // ADDIWB | write addi result to rt
  // TRAP   | load trap vector for an unknown opcode
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_wait;
  logic [RETIRE_W-1:0] r_retire_cnt;
  logic                r_mem_timeout;
  logic                w_stall;
  logic                w_timeout;
  logic                w_retire;
  logic                w_unused_zero;

  // The branch decision itself is taken in the datapath through pc_write_cond.
  assign w_unused_zero = zero;

  assign state       = r_state;
  assign retire_cnt  = r_retire_cnt;
  assign mem_timeout = r_mem_timeout;

  // Controls are gated by rst_n so nothing is driven while reset is held.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b11;
          illegal_op = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign w_stall   = mem_req & ~mem_ready;
  assign w_timeout = w_stall && (r_wait == WAIT_LAST);

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
`endif
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_wait        <= 8'd0;
      r_retire_cnt  <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter restarts on completion, timeout, or any cycle without a pending request.
      if (w_stall && !w_timeout) r_wait <= r_wait + 8'd1;
      else                       r_wait <= 8'd0;
      if (w_timeout) r_mem_timeout <= 1'b1;
      if (w_retire)  r_retire_cnt  <= r_retire_cnt + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expectations, a monitor checks them.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] tag;
    logic [3:0]  st;
    ctrl_t       c;
    logic [31:0] ret;
    logic        to;
  } exp_t;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [3:0]  state;
  logic [31:0] retire_cnt;
  logic        mem_timeout, illegal_op;

  ctrl_t       act_c;
  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          tag = 0;
  int          r_after_bad;

  multicycle_control #(.RETIRE_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state), .retire_cnt(retire_cnt),
    .mem_timeout(mem_timeout), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign act_c = '{mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                   alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

  // Expected controls for each state, written from the state behaviour table.
  function automatic ctrl_t ctrl_of(input logic [3:0] st, input logic rdy);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_req = 1; c.i_or_d = 1; end
      4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd5:  begin c.mem_req = 1; c.mem_write = 1; c.i_or_d = 1; end
      4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd11: c.reg_write = 1;
      4'd12: begin c.pc_write = 1; c.pc_source = 2'b11; c.illegal_op = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] est,
                     input int eret, input logic eto);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b1; opcode = op; mem_ready = rdy;
    e.tag = 32'(tag); e.st = est; e.c = ctrl_of(est, rdy); e.ret = 32'(eret); e.to = eto;
    tag++;
    q.push_back(e);
  endtask

  task automatic rst_cyc();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b1;
    e.tag = 32'(tag); e.st = 4'd0; e.c = '0; e.ret = 32'd0; e.to = 1'b0;
    tag++;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (state !== e.st || act_c !== e.c || retire_cnt !== e.ret || mem_timeout !== e.to) begin
        failures++;
        $display("FAIL step%0d: state act=%0d exp=%0d ctrl act=%h exp=%h retire act=%0d exp=%0d timeout act=%b exp=%b",
                 e.tag, state, e.st, act_c, e.c, retire_cnt, e.ret, mem_timeout, e.to);
      end
    end
  end

  initial begin
    // reset state
    rst_cyc(); rst_cyc();
    // lw, no stalls: 5 cycles
    cyc(LW, 1, 0, 0, 0); cyc(LW, 1, 1, 0, 0); cyc(LW, 1, 2, 0, 0);
    cyc(LW, 1, 3, 0, 0); cyc(LW, 1, 4, 0, 0);
    // R-type then beq
    cyc(RT, 1, 0, 1, 0); cyc(RT, 1, 1, 1, 0); cyc(RT, 1, 6, 1, 0); cyc(RT, 1, 7, 1, 0);
    cyc(BEQ, 1, 0, 2, 0); cyc(BEQ, 1, 1, 2, 0); cyc(BEQ, 1, 8, 2, 0);
    // fetch stalled 3 cycles, then a jump
    for (int i = 0; i < 3; i++) cyc(JMP, 0, 0, 3, 0);
    cyc(JMP, 1, 0, 3, 0); cyc(JMP, 1, 1, 3, 0); cyc(JMP, 1, 9, 3, 0);
    // addi
    cyc(ADDI, 1, 0, 4, 0); cyc(ADDI, 1, 1, 4, 0); cyc(ADDI, 1, 10, 4, 0); cyc(ADDI, 1, 11, 4, 0);
    // sw never acknowledged: 15 stalled cycles then timeout
    cyc(SW, 1, 0, 5, 0); cyc(SW, 1, 1, 5, 0); cyc(SW, 1, 2, 5, 0);
    for (int i = 0; i < 15; i++) cyc(SW, 0, 5, 5, 0);
    // sw acknowledged on the 15th cycle: completion wins, timeout stays sticky
    cyc(SW, 1, 0, 5, 1); cyc(SW, 1, 1, 5, 1); cyc(SW, 1, 2, 5, 1);
    for (int i = 0; i < 14; i++) cyc(SW, 0, 5, 5, 1);
    cyc(SW, 1, 5, 5, 1);
    // unknown opcode
    cyc(BAD, 1, 0, 6, 1); cyc(BAD, 1, 1, 6, 1);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc(BAD, 1, 12, 6, 1);
    r_after_bad = 6;
`else
    r_after_bad = 7;
`endif
    // reset in the middle of a stalled lw read
    cyc(LW, 1, 0, r_after_bad, 1); cyc(LW, 1, 1, r_after_bad, 1); cyc(LW, 1, 2, r_after_bad, 1);
    cyc(LW, 0, 3, r_after_bad, 1); cyc(LW, 0, 3, r_after_bad, 1);
    rst_cyc(); rst_cyc();
    cyc(LW, 0, 0, 0, 0); cyc(LW, 1, 0, 0, 0); cyc(LW, 1, 1, 0, 0); cyc(LW, 1, 2, 0, 0);
    cyc(LW, 1, 3, 0, 0); cyc(LW, 1, 4, 0, 0); cyc(RT, 0, 0, 1, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending act=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
